// File: rtl/sound_frame_seq_if.sv
// Frame sequencer control/tick bundle between sound power logic and channels.
// div_bit exists only when SOUND_FRAME_DIV_SYNC_EN is defined.
interface sound_frame_seq_if;
  logic       sound_enable;
`ifdef SOUND_FRAME_DIV_SYNC_EN
  logic       div_bit;
`endif
  logic       frame_tick;
  logic       length_tick;
  logic       sweep_tick;
  logic       env_tick;
  logic [2:0] step;
  logic       length_next;

`ifdef SOUND_FRAME_DIV_SYNC_EN
  modport master (
    input  sound_enable,
    input  div_bit,
    output frame_tick,
    output length_tick,
    output sweep_tick,
    output env_tick,
    output step,
    output length_next
  );
  modport slave (
    output sound_enable,
    output div_bit,
    input  frame_tick,
    input  length_tick,
    input  sweep_tick,
    input  env_tick,
    input  step,
    input  length_next
  );
`else
  modport master (
    input  sound_enable,
    output frame_tick,
    output length_tick,
    output sweep_tick,
    output env_tick,
    output step,
    output length_next
  );
  modport slave (
    output sound_enable,
    input  frame_tick,
    input  length_tick,
    input  sweep_tick,
    input  env_tick,
    input  step,
    input  length_next
  );
`endif
endinterface

// File: rtl/sound_frame_seq.sv
// Sound frame sequencer: 512 Hz step clock, 8-step length/sweep/env ticks.
// Define SOUND_FRAME_DIV_SYNC_EN to step on DIV bit 12 falling edges instead.
module sound_frame_seq #(
  parameter int DIV_RATIO = 8192,
  parameter int CNT_WIDTH = 13
) (
  input logic           clk,
  input logic           rst,
  sound_frame_seq_if.master sif
);

  logic       en;
  logic       fire;
  logic [2:0] step_q;
  logic [2:0] step_d;
  logic [3:0] tick_q;
  logic [3:0] tick_d;

  assign en = sif.sound_enable;

`ifdef SOUND_FRAME_DIV_SYNC_EN
  logic div_q;

  // Held clear while powered off so an edge in flight at power-on is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= 1'b0;
    else      div_q <= en & sif.div_bit;
  end

  assign fire = en & div_q & ~sif.div_bit;
`else
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DIV_RATIO - 1);

  logic [CNT_WIDTH-1:0] presc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc <= '0;
    else if (!en || presc == LAST)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  assign fire = en & (presc == LAST);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
      tick_q <= '0;
    end else begin
      step_q <= step_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    step_d = step_q;
    unique case (1'b1)
      !en:     step_d = '0;
      fire:    step_d = step_q + 3'd1;
      default: step_d = step_q;
    endcase
  end

  // {frame, length, sweep, env}
  always_comb begin
    tick_d = '0;
    if (fire)
      tick_d = {1'b1,
                ~step_q[0],
                step_q[1:0] == 2'b10,
                step_q == 3'd7};
  end

  assign sif.frame_tick  = tick_q[3];
  assign sif.length_tick = tick_q[2];
  assign sif.sweep_tick  = tick_q[1];
  assign sif.env_tick    = tick_q[0];
  assign sif.step        = step_q;
  assign sif.length_next = ~step_q[0];

endmodule

// File: tb/tb_sound_frame_seq.sv
// Scoreboard bench for sound_frame_seq against a power/step reference model.
// Honours SOUND_FRAME_DIV_SYNC_EN for the DIV-synchronised timing variant.
module tb_sound_frame_seq;

  localparam int DIV = 8;

  typedef struct {
    int         edge_n;
    logic [2:0] step;
  } exp_t;

  logic clk;
  logic rst;
  sound_frame_seq_if sif ();

  sound_frame_seq #(
    .DIV_RATIO(DIV),
    .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests;
  int   fails;
  int   edge_cnt;
  exp_t q[$];

  int         run_len;
  logic [2:0] m_step;
  logic       m_prev_div;
  logic       div_val;
  int         dcnt;
  bit         m_fired;
  int         n_ft, n_lt, n_st, n_et;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: a step fires after every DIV-th consecutive powered edge
  // (or on a powered DIV falling edge in the sync variant).
  task automatic model(input logic en, input logic rb);
    bit f;
    f = 1'b0;
    if (!rb || !en) begin
      run_len    = 0;
      m_step     = 3'd0;
      m_prev_div = 1'b0;
    end else begin
`ifdef SOUND_FRAME_DIV_SYNC_EN
      f = m_prev_div && !div_val;
      m_prev_div = div_val;
`else
      run_len++;
      f = (run_len % DIV) == 0;
`endif
      if (f) begin
        q.push_back('{edge_n: edge_cnt, step: m_step});
        m_step = 3'((int'(m_step) + 1) % 8);
      end
    end
    m_fired = f;
  endtask

  task automatic tick(input logic en, input logic rb);
    sif.sound_enable = en;
    rst = rb;
    dcnt++;
    div_val = dcnt[3];
`ifdef SOUND_FRAME_DIV_SYNC_EN
    sif.div_bit = div_val;
`endif
    @(posedge clk);
    edge_cnt++;
    model(en, rb);
    #1;
  endtask

  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] expv;
    logic [2:0] s;
    while (q.size() > 0 && q[0].edge_n < edge_cnt) begin
      chk("missed_pulse", 32'(q[0].edge_n), 32'(edge_cnt));
      void'(q.pop_front());
    end
    act = {sif.frame_tick, sif.length_tick,
           sif.sweep_tick, sif.env_tick, sif.step};
    n_ft += int'(sif.frame_tick);
    n_lt += int'(sif.length_tick);
    n_st += int'(sif.sweep_tick);
    n_et += int'(sif.env_tick);
    if (act[6:3] != 4'd0) begin
      if (q.size() == 0) begin
        chk("spurious_tick", 32'(act), 32'(0));
      end else begin
        s = q[0].step;
        expv = {1'b1, s % 3'd2 == 3'd0,
                s == 3'd2 || s == 3'd6,
                s == 3'd7, 3'((int'(s) + 1) % 8)};
        chk("pulse", 32'(act), 32'(expv));
        void'(q.pop_front());
      end
    end
    chk("step_lnext", 32'({sif.step, sif.length_next}),
        32'({m_step, m_step % 3'd2 == 3'd0}));
  end

  initial begin
    int guard;
    logic en_r;
    tests = 0; fails = 0; edge_cnt = 0; dcnt = 0;
    run_len = 0; m_step = 3'd0; m_prev_div = 1'b0;
    div_val = 1'b0; m_fired = 1'b0;
    n_ft = 0; n_lt = 0; n_st = 0; n_et = 0;
    rst = 1'b0;
    sif.sound_enable = 1'b0;
`ifdef SOUND_FRAME_DIV_SYNC_EN
    sif.div_bit = 1'b0;
`endif

    repeat (3) tick(1'b1, 1'b0);
    chk("rst_ticks", 32'({sif.frame_tick, sif.length_tick,
        sif.sweep_tick, sif.env_tick}), 32'(0));
    chk("rst_step", 32'(sif.step), 32'(0));
    chk("rst_lnext", 32'(sif.length_next), 32'(1));

    @(negedge clk); #1;
    n_ft = 0; n_lt = 0; n_st = 0; n_et = 0;
    repeat (64) tick(1'b1, 1'b1);
    @(negedge clk); #1;
`ifndef SOUND_FRAME_DIV_SYNC_EN
    chk("cnt_frame", 32'(n_ft), 32'(8));
    chk("cnt_length", 32'(n_lt), 32'(4));
    chk("cnt_sweep", 32'(n_st), 32'(2));
    chk("cnt_env", 32'(n_et), 32'(1));
`endif

    tick(1'b0, 1'b1);
    repeat (3 * DIV + 5) tick(1'b1, 1'b1);
    @(negedge clk); #1;
    n_ft = 0;
    repeat (20) tick(1'b0, 1'b1);
    @(negedge clk); #1;
    chk("off_no_ticks", 32'(n_ft), 32'(0));
    chk("off_step", 32'(sif.step), 32'(0));
    repeat (2 * DIV + 2) tick(1'b1, 1'b1);

    guard = 0;
    m_fired = 1'b0;
    while (!m_fired && guard < 40) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    chk("rst_pulse_found", 32'(m_fired), 32'(1));
    chk("pre_rst_tick", 32'(sif.frame_tick), 32'(1));
    rst = 1'b0;
    #1;
    chk("async_rst_ticks", 32'({sif.frame_tick, sif.length_tick,
        sif.sweep_tick, sif.env_tick}), 32'(0));
    chk("async_rst_step", 32'(sif.step), 32'(0));
    q.delete();
    run_len = 0; m_step = 3'd0; m_prev_div = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    repeat (3 * DIV + 3) tick(1'b1, 1'b1);

    en_r = 1'b1;
    repeat (3000) begin
      if (en_r && $urandom_range(0, 39) == 0) en_r = 1'b0;
      else if (!en_r && $urandom_range(0, 7) == 0) en_r = 1'b1;
      tick(en_r, 1'b1);
    end

    repeat (2) tick(1'b0, 1'b1);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
